// File: rtl/rns_lane_sched_pkg.sv
// Shared definitions for the rns lane sequencer: default widths and the state encoding.
package rns_lane_sched_pkg;

    localparam int LWIDTH_D  = 64;
    localparam int SWIDTH_D  = 16;
    localparam int NUM_MOD_D = 4;
    localparam int IDX_W_D   = 2;
    localparam int TIMEOUT_D = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rns_lane_sched.sv
// Time-shares one rns reduction lane across NUM_MOD moduli: latches an operand, issues it once per
// modulus index, gathers the in-order residues into a packed vector and hands it downstream.
module rns_lane_sched
    import rns_lane_sched_pkg::*;
#(
    parameter int LWIDTH  = LWIDTH_D,
    parameter int SWIDTH  = SWIDTH_D,
    parameter int NUM_MOD = NUM_MOD_D,
    parameter int IDX_W   = IDX_W_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [LWIDTH-1:0]         i_in_a,
    output logic                      o_lane_valid,
    output logic [IDX_W-1:0]          o_lane_sel,
    output logic [LWIDTH-1:0]         o_lane_a,
    input  logic                      i_lane_rvalid,
    input  logic [SWIDTH-1:0]         i_lane_res,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [NUM_MOD*SWIDTH-1:0] o_out_res,
    output logic                      o_err_unexp,
    output logic                      o_err_timeout
);

    localparam int              CW     = IDX_W + 1;
    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST   = CW'(NUM_MOD - 1);
    // Loaded one short so the abort lands exactly TIMEOUT cycles after the reload event.
    localparam logic [TW-1:0]   RELOAD = TW'(TIMEOUT - 1);

    state_t                    r_state, w_next;
    logic [CW-1:0]             r_issue_cnt, r_resp_cnt;
    logic [TW-1:0]             r_tmo;
    logic [LWIDTH-1:0]         r_a;
    logic [NUM_MOD*SWIDTH-1:0] r_res;
    logic                      r_in_ready, r_err_unexp, r_err_tmo;

    logic w_accept, w_busy, w_rsp_ok, w_rsp_bad, w_last_rsp, w_tmo_fire;

    assign w_accept   = (r_state == S_IDLE) && r_in_ready && i_in_valid;
    assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
    // A response is only legal while something issued is still outstanding.
    assign w_rsp_ok   = i_lane_rvalid && w_busy && (r_resp_cnt != r_issue_cnt);
    assign w_rsp_bad  = i_lane_rvalid && !w_rsp_ok;
    assign w_last_rsp = w_rsp_ok && (r_resp_cnt == LAST);
    assign w_tmo_fire = (r_state == S_WAIT) && !w_rsp_ok && (r_tmo <= TW'(1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: if (r_issue_cnt == LAST) w_next = S_WAIT;
            S_WAIT: begin
                if (w_last_rsp)      w_next = S_DONE;
                else if (w_tmo_fire) w_next = S_IDLE;
            end
            S_DONE:  if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
            r_tmo       <= '0;
            r_a         <= '0;
            r_res       <= '0;
            r_err_unexp <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_a         <= i_in_a;
                r_issue_cnt <= '0;
                r_resp_cnt  <= '0;
            end else if (r_state == S_ISSUE) begin
                r_issue_cnt <= r_issue_cnt + CW'(1);
            end
            if (w_rsp_ok) r_resp_cnt <= r_resp_cnt + CW'(1);
            if ((r_state == S_ISSUE) || w_rsp_ok) r_tmo <= RELOAD;
            else if (r_state == S_WAIT)            r_tmo <= r_tmo - TW'(1);
            for (int i = 0; i < NUM_MOD; i++)
                if (w_rsp_ok && (r_resp_cnt == CW'(i))) r_res[i*SWIDTH +: SWIDTH] <= i_lane_res;
            if (w_rsp_bad)  r_err_unexp <= 1'b1;
            if (w_tmo_fire) r_err_tmo   <= 1'b1;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_lane_valid  = (r_state == S_ISSUE);
    assign o_lane_sel    = r_issue_cnt[IDX_W-1:0];
    assign o_lane_a      = r_a;
    assign o_out_valid   = (r_state == S_DONE);
    assign o_out_res     = r_res;
    assign o_err_unexp   = r_err_unexp;
    assign o_err_timeout = r_err_tmo;

endmodule
